// File: rtl/fetch_pc.sv
// Program-counter stage at the head of fetch: sequential addresses over a bounded IMEM,
// execute redirects, halt at end of IMEM. Optional redirect alignment check: FETCH_PC_ALIGN_CHECK_EN.
module fetch_pc #(
  parameter int unsigned            XLEN       = 32,
  parameter logic [XLEN-1:0]        RESET_VEC  = '0,
  parameter int unsigned            INST_BYTES = 4,
  parameter int unsigned            IMEM_WORDS = 128,
  parameter int unsigned            CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ready,
  input  logic [XLEN:0]    i_redirect,   // Signals packet {valid, pc}
  output logic [XLEN:0]    o_signals,    // Signals packet {valid, pc}
  output logic             o_halted,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned     ALIGN_BITS = (INST_BYTES == 2) ? 1 : 2;
  localparam logic [XLEN-1:0] SPAN       = XLEN'((IMEM_WORDS - 1) * INST_BYTES);
  localparam logic [XLEN-1:0] LAST_PC    = RESET_VEC + SPAN;
  localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << ALIGN_BITS) - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } signals_t;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;

  signals_t        redirect;
  logic [XLEN-1:0] tgt;
  logic            tgt_in_range;
  logic            tgt_misaligned;
  logic            fire;

  assign redirect = signals_t'(i_redirect);
  assign fire     = valid_q & i_ready;

`ifdef FETCH_PC_ALIGN_CHECK_EN
  assign tgt            = redirect.pc;
  assign tgt_misaligned = |(redirect.pc & ALIGN_MASK);
`else
  // Without the check, low bits are silently dropped before range checking.
  assign tgt            = redirect.pc & ~ALIGN_MASK;
  assign tgt_misaligned = 1'b0;
`endif

  // Offset compare folds both bounds into one unsigned test.
  assign tgt_in_range = (tgt - RESET_VEC) <= SPAN;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    count_d = count_q;

    if (fire && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_RUN: begin
        if (redirect.valid) begin
          if (tgt_misaligned) begin
            state_d = ST_FAULT;
            valid_d = 1'b0;
          end else if (tgt_in_range) begin
            pc_d    = tgt;
            valid_d = 1'b1;
          end else begin
            state_d = ST_HALT;
            valid_d = 1'b0;
          end
        end else if (fire) begin
          if (pc_q == LAST_PC) begin
            state_d = ST_HALT;
            valid_d = 1'b0;
          end else begin
            pc_d = pc_q + STEP;
          end
        end
      end

      ST_HALT: begin
        valid_d = 1'b0;
        if (redirect.valid) begin
          if (tgt_misaligned) begin
            state_d = ST_FAULT;
          end else if (tgt_in_range) begin
            state_d = ST_RUN;
            pc_d    = tgt;
            valid_d = 1'b1;
          end
        end
      end

      ST_FAULT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      valid_q <= 1'b1;
      pc_q    <= RESET_VEC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign o_signals = {valid_q, pc_q};
  assign o_halted  = (state_q == ST_HALT);
  assign o_count   = count_q;
`ifdef FETCH_PC_ALIGN_CHECK_EN
  assign o_fault   = (state_q == ST_FAULT);
`else
  assign o_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: a reference model pushes expected outputs per driven cycle,
// popped and compared one edge later; plus directed checks from the test plan.
module tb_fetch_pc;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] LAST  = 32'h1FC;
  localparam logic [7:0]  CMAX  = 8'hFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_ready;
  logic [XLEN:0]    i_redirect;
  logic [XLEN:0]    o_signals;
  logic             o_halted;
  logic             o_fault;
  logic [CNT_W-1:0] o_count;

  fetch_pc #(.XLEN(XLEN), .RESET_VEC('0), .INST_BYTES(4), .IMEM_WORDS(128), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_ready(i_ready), .i_redirect(i_redirect),
    .o_signals(o_signals), .o_halted(o_halted), .o_fault(o_fault), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        halted;
    logic        fault;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: 0 run, 1 halt, 2 fault.
  int          m_st  = 0;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [7:0]  m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        fire;
    logic        mis;
    logic        inr;
    logic [31:0] t;
    if (r) begin
      m_st = 0; m_valid = 1'b1; m_pc = 32'h0; m_cnt = 8'h0;
    end else begin
      fire = m_valid && rdy;
      if (fire && m_cnt != CMAX) m_cnt = m_cnt + 8'd1;
`ifdef FETCH_PC_ALIGN_CHECK_EN
      t   = rpc;
      mis = (rpc[1:0] != 2'b00);
`else
      t   = {rpc[31:2], 2'b00};
      mis = 1'b0;
`endif
      inr = (t <= LAST);
      if (m_st == 0) begin
        if (rv) begin
          if (mis) begin m_st = 2; m_valid = 1'b0; end
          else if (inr) begin m_pc = t; m_valid = 1'b1; end
          else begin m_st = 1; m_valid = 1'b0; end
        end else if (fire) begin
          if (m_pc == LAST) begin m_st = 1; m_valid = 1'b0; end
          else m_pc = m_pc + 32'd4;
        end
      end else if (m_st == 1) begin
        if (rv) begin
          if (mis) m_st = 2;
          else if (inr) begin m_st = 0; m_pc = t; m_valid = 1'b1; end
        end
      end
    end
    exp_q.push_back('{valid: m_valid, pc: m_pc, halted: (m_st == 1), fault: (m_st == 2), cnt: m_cnt});
  endtask

  // One clock: drive at negedge, record expectation, compare #1 after the rising edge.
  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    rst = r; i_ready = rdy; i_redirect = {rv, rpc};
    model(r, rdy, rv, rpc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("valid",  64'(o_signals[XLEN]),     64'(e.valid));
    check("pc",     64'(o_signals[XLEN-1:0]), 64'(e.pc));
    check("halted", 64'(o_halted),            64'(e.halted));
    check("fault",  64'(o_fault),             64'(e.fault));
    check("count",  64'(o_count),             64'(e.cnt));
  endtask

  initial begin
    logic [31:0] rt;
    int          k;
    rst = 1'b1; i_ready = 1'b0; i_redirect = '0;

    // Reset with a pending redirect: reset wins.
    cyc(1'b1, 1'b1, 1'b1, 32'h40);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_pc",    64'(o_signals[XLEN-1:0]), 64'h0);
    check("rst_valid", 64'(o_signals[XLEN]),     64'h1);
    check("rst_count", 64'(o_count),             64'h0);

    // Free run through the whole IMEM.
    for (int i = 0; i < 128; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("end_halted", 64'(o_halted),            64'h1);
    check("end_valid",  64'(o_signals[XLEN]),     64'h0);
    check("end_pc",     64'(o_signals[XLEN-1:0]), 64'h1FC);
    check("end_count",  64'(o_count),             64'd128);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h200);
    check("halt_ignore_oor", 64'(o_halted), 64'h1);

    // Restart from HALT.
    cyc(1'b0, 1'b0, 1'b1, 32'h20);
    check("restart_valid",  64'(o_signals[XLEN]),     64'h1);
    check("restart_pc",     64'(o_signals[XLEN-1:0]), 64'h20);
    check("restart_halted", 64'(o_halted),            64'h0);

    // Out-of-range redirect halts.
    cyc(1'b0, 1'b0, 1'b1, 32'h200);
    check("oor_halted", 64'(o_halted),        64'h1);
    check("oor_valid",  64'(o_signals[XLEN]), 64'h0);

    // Backpressure at 0x10.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_pc0", 64'(o_signals[XLEN-1:0]), 64'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      check("bp_hold_pc",    64'(o_signals[XLEN-1:0]), 64'h10);
      check("bp_hold_count", 64'(o_count),             64'd4);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_next_pc", 64'(o_signals[XLEN-1:0]), 64'h14);
    check("bp_count",   64'(o_count),             64'd5);

    // Redirect with a same-cycle fire.
    cyc(1'b0, 1'b0, 1'b1, 32'h8);
    cyc(1'b0, 1'b1, 1'b1, 32'h40);
    check("rf_pc",    64'(o_signals[XLEN-1:0]), 64'h40);
    check("rf_count", 64'(o_count),             64'd6);

    // Misaligned redirect.
    cyc(1'b0, 1'b0, 1'b1, 32'h22);
`ifdef FETCH_PC_ALIGN_CHECK_EN
    check("mis_fault", 64'(o_fault),           64'h1);
    check("mis_valid", 64'(o_signals[XLEN]),   64'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h20);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("fault_sticky", 64'(o_fault), 64'h1);
`else
    check("mis_pc",    64'(o_signals[XLEN-1:0]), 64'h20);
    check("mis_fault", 64'(o_fault),             64'h0);
`endif

    // Reset mid-stream with a redirect pending.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h30);
    cyc(1'b1, 1'b1, 1'b1, 32'h40);
    check("mid_rst_pc",    64'(o_signals[XLEN-1:0]), 64'h0);
    check("mid_rst_valid", 64'(o_signals[XLEN]),     64'h1);
    check("mid_rst_count", 64'(o_count),             64'h0);

    // Counter saturation: two full passes exceed 255 fires.
    for (int i = 0; i < 128; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 130; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("sat_count", 64'(o_count), 64'hFF);

    // Randomised traffic against the model.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 99));
      case ($urandom_range(0, 5))
        0: rt = 32'h200 + ($urandom_range(0, 15) << 2);
        1: rt = 32'hFFFF_FFFC;
        2: rt = LAST;
        3: rt = {$urandom_range(0, 127), 2'b00} | 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
        default: rt = {$urandom_range(0, 127), 2'b00};
      endcase
      cyc(k < 3, ($urandom_range(0, 3) != 0), (k >= 3 && k < 15), rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Parametrised program-counter stage at the head of the fetch pipeline. Generates sequential fetch addresses over a bounded instruction memory, handing each out as a `Signals` packet (`valid`, `pc`) under a ready/valid handshake. Accepts taken-branch/jump redirects from execute, halts cleanly at the end of instruction memory and can be restarted by a redirect. Counts retired fetches.

## Interface
Parameters:
- `XLEN`, 32: address width; `Signals.pc` width.
- `RESET_VEC`, 0: first fetch address after reset; multiple of `INST_BYTES`.
- `INST_BYTES`, 4: bytes per instruction; 2 or 4.
- `IMEM_WORDS`, 128: instruction-memory depth in instructions; ≥ 1.
- `CNT_W`, 32: fetch-counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_ready`  in  1  downstream accepts `o_signals` this cycle.
- `i_redirect`  in  `Signals`  `valid` = redirect request; `pc` = target address.
- `o_signals`  out  `Signals`  `valid` = fetch address presented; `pc` = fetch address.
- `o_halted`  out  1  high in HALT.
- `o_fault`  out  1  high in FAULT (tied 0 without `FETCH_PC_ALIGN_CHECK_EN`).
- `o_count`  out  `CNT_W`  fetches accepted since reset; saturating.

## Operation
- `LAST_PC = RESET_VEC + (IMEM_WORDS-1)*INST_BYTES`. A target is in range iff `RESET_VEC ≤ pc ≤ LAST_PC`, compared unsigned at `XLEN`.
- Fire: `o_signals.valid && i_ready`.
- States: RUN, HALT, FAULT.
- Reset, sampled on an edge with `rst`=1: state RUN; `o_signals.valid`=1; `o_signals.pc`=`RESET_VEC`; `o_halted`=0; `o_fault`=0; `o_count`=0. Reset overrides every other input, including mid-redirect and from FAULT.
- RUN, priority order:
  - Redirect valid, target in range and aligned: `pc` ← target, `valid`=1. The currently presented address is dropped, but is still counted if it fires this cycle.
  - Redirect valid, target out of range: → HALT; `valid`=0; `pc` holds its value.
  - Fire with `pc == LAST_PC`: → HALT; `valid`=0; `pc` holds `LAST_PC`.
  - Fire otherwise: `pc` ← `pc + INST_BYTES`, modulo 2^XLEN; `valid` stays 1.
  - No fire: `pc` and `valid` hold. The address is stable until accepted.
- HALT:
  - `valid`=0; `o_halted`=1.
  - An in-range, aligned redirect → RUN with `pc` = target, `valid`=1, `o_halted`=0.
  - Out-of-range redirects are ignored.
  - `i_ready` is ignored.
- FAULT: `valid`=0; `o_fault`=1. The state is sticky until `rst`; redirects are ignored.
- `o_count` increments by 1 on each fire and saturates at all-ones.

## Timing
- Every output is a register; there is no combinational path from any input to any output.
- Redirect-to-output latency: 1 cycle. A redirect sampled at edge N is visible on `o_signals` after edge N.
- Sequential advance: 1 address per cycle while `i_ready`=1. This is full throughput with no bubbles.
- HALT is entered at the edge that accepts `LAST_PC`. `valid` is low from the following cycle.
- Restart from HALT: 1 cycle from redirect to `valid`=1.
- A redirect and a fire in the same cycle produce one count increment, and the next `pc` is the redirect target.
- `rst` together with a redirect: reset wins.

## Configuration
- `FETCH_PC_ALIGN_CHECK_EN` defined:
  - A redirect target with `pc % INST_BYTES != 0` is misaligned. In RUN or HALT it moves the block to FAULT, with `valid`=0 and `o_fault`=1 after 1 cycle.
  - The misalignment check takes priority over the range check.
- `FETCH_PC_ALIGN_CHECK_EN` not defined:
  - The low `log2(INST_BYTES)` bits of the target are cleared, then the range rules apply.
  - FAULT is unreachable, and `o_fault` is constant 0.

## Test plan
- Reset then free-run, with defaults and `i_ready`=1:
  - `pc` steps 0, 4, 8, …, 0x1FC.
  - `o_halted`=1 one cycle after 0x1FC fires.
  - `o_count`=128.
- Backpressure: `i_ready`=0 for 3 cycles while `pc`=0x10. Required response:
  - `pc` holds 0x10 with `valid`=1.
  - After `i_ready` rises, 0x10 is accepted exactly once, then 0x14 follows.
  - `o_count` increments by 1.
- Redirect with a same-cycle fire: redirect to 0x40 while `pc`=0x8 fires. Required response: next `pc`=0x40 and `o_count` +1. Separately, a redirect to 0x200 → HALT with `valid`=0.
- Restart from HALT: a redirect to 0x20 → `valid`=1 and `pc`=0x20 on the next cycle, with `o_halted`=0.
- Misaligned redirect to 0x22:
  - With the macro: `o_fault`=1, and the block stays in FAULT until `rst`.
  - Without the macro: `pc`=0x20.
- Reset mid-stream: assert `rst` with a redirect to 0x40 pending while `pc`=0x30. Required response: `pc`=`RESET_VEC`, `valid`=1, `o_count`=0.
